rv_wb_unit: RTL and testbench
=============================

RV_WB_UNIT -- requirements
Module: rv_wb_unit

Interface
REQ-001 SHALL have parameter LSU_DEPTH, default 2, load-result buffer depth in entries (power of two, >= 2).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports alu_valid_i input 1, alu_ready_o output 1, alu_addr_i input 5, alu_data_i input 32: execute-stage writeback request, valid/ready handshake.
REQ-005 SHALL have ports lsu_valid_i input 1, lsu_ready_o output 1, lsu_addr_i input 5, lsu_data_i input 32: load-unit writeback request, valid/ready handshake.
REQ-006 SHALL have ports wr_en_o output 1, wr_addr_o output 5, wr_data_o output 32: register-file write port (initiator side), all registered.

Function
REQ-007 SHALL complete a handshake on a source in any cycle where its valid and ready are both 1; a transfer never completes otherwise.
REQ-008 SHALL push each accepted LSU request into a FIFO of LSU_DEPTH entries with count 0..LSU_DEPTH; pointers wrap modulo LSU_DEPTH.
REQ-009 SHALL drive lsu_ready_o = (count < LSU_DEPTH) and alu_ready_o = (count < LSU_DEPTH), both combinational from registered state only.
REQ-010 SHALL select one write per cycle: FIFO full -> pop FIFO head; else alu handshake -> ALU request; else FIFO non-empty -> pop head; else none.
REQ-011 SHALL allow push and pop in the same cycle; count then stays unchanged; push to a full FIFO never occurs (ready low).
REQ-012 SHALL present the selected write on wr_en_o/wr_addr_o/wr_data_o in the following cycle (latency 1), wr_en_o high exactly one cycle per write.
REQ-013 SHALL accept requests with address 0 normally (handshake, FIFO slot, pop) but keep wr_en_o = 0 for them; wr_addr_o/wr_data_o hold previous values.
REQ-014 SHALL hold wr_addr_o/wr_data_o unchanged in cycles with no write.
REQ-015 SHALL retire LSU requests strictly in acceptance order; no ordering between ALU and LSU streams is guaranteed.
REQ-016 SHALL not depend on valid being held: a deasserted valid without handshake is legal and drops nothing already accepted.

Reset
REQ-017 SHALL, while rst_ni = 0, force count = 0, read/write pointers = 0, wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0.
REQ-018 SHALL drive alu_ready_o = 1 and lsu_ready_o = 1 during and directly after reset (FIFO empty).
REQ-019 SHALL discard all buffered LSU entries on reset mid-operation; no write is issued after rst_ni deasserts until a new handshake.

Configuration
REQ-020 SHALL, with macro RV_WB_HAZARD_EN defined, add ports query_addr_i input 5 and query_hit_o output 1.
REQ-021 SHALL drive query_hit_o = 1 combinationally when query_addr_i != 0 and equals the address of any valid FIFO entry or of a write pending on wr_en_o this cycle; else 0 (0 in reset).
REQ-022 SHALL, without RV_WB_HAZARD_EN, omit both ports and the comparison logic; all other behaviour identical.

Verification
REQ-023 SHALL verify: ALU req addr 5 data 0x1234 in cycle N -> wr_en_o=1, wr_addr_o=5, wr_data_o=0x1234 in cycle N+1 only.
REQ-024 SHALL verify: ALU and LSU valid every cycle, LSU addrs 1,2,3 -> ALU writes first, FIFO fills to 2, alu_ready_o=0, LSU writes 1,2,3 retire in order.
REQ-025 SHALL verify: ALU req addr 0 data 0xFFFFFFFF -> handshake completes, wr_en_o stays 0, wr_data_o unchanged.
REQ-026 SHALL verify: FIFO holding 2 entries, rst_ni pulsed low mid-cycle -> outputs 0 immediately, both ready=1, no writes after release.
REQ-027 SHALL verify: with RV_WB_HAZARD_EN, LSU addr 7 buffered behind ALU traffic, query_addr_i=7 -> query_hit_o=1 until the write cycle ends; query_addr_i=0 -> 0.
REQ-028 SHALL verify: FIFO count 1, simultaneous LSU push and no ALU -> head popped, new entry stored, count remains 1, lsu_ready_o stays 1.

Source files
------------

// File: rtl/rv_wb_unit.sv
// rv_wb_unit -- register-file writeback arbiter.
//
// Merges two writeback sources onto a single register-file write port:
//   * the execute stage (ALU), which is written straight through, and
//   * the load unit (LSU), whose results queue in a small in-order FIFO.
// One write is issued per cycle.
//
// Arbitration:
//   * A full FIFO always drains first; ALU ready is low in that case.
//   * Otherwise an ALU handshake wins.
//   * Otherwise a non-empty FIFO pops its head.
// Writes appear on the write port one cycle after selection.
// Writes to x0 are accepted and consumed but never assert wr_en_o.
//
// Parameters:
//   LSU_DEPTH     load-result FIFO depth (power of two, >= 2)
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   alu_valid_i/alu_ready_o         ALU writeback handshake
//   alu_addr_i/alu_data_i           ALU destination register and value
//   lsu_valid_i/lsu_ready_o         LSU writeback handshake
//   lsu_addr_i/lsu_data_i           LSU destination register and value
//   wr_en_o/wr_addr_o/wr_data_o     registered register-file write port
//
// Optional feature (macro RV_WB_HAZARD_EN):
//   query_addr_i  register to look up
//   query_hit_o   high when a write to that register is still in flight
//                 (buffered in the FIFO or on the write port this cycle)

module rv_wb_unit #(
    parameter int LSU_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_addr_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        wr_en_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] wr_data_o
`ifdef RV_WB_HAZARD_EN
    ,
    input  logic [4:0]  query_addr_i,
    output logic        query_hit_o
`endif
);

    localparam int PTR_W = $clog2(LSU_DEPTH);
    localparam int CNT_W = $clog2(LSU_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_DEPTH);

    // FIFO control and storage
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       fifo_addr_q [LSU_DEPTH];
    logic [31:0]      fifo_data_q [LSU_DEPTH];

    // Write-port registers
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic        alu_fire;
    logic        lsu_fire;
    logic        pop;
    logic        sel_valid;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);

    // Both sources stall together on a full FIFO. This reserves the write
    // slot for draining it, so the ALU cannot starve the load queue.
    assign alu_ready_o = (count_q < DEPTH_C);
    assign lsu_ready_o = (count_q < DEPTH_C);

    assign alu_fire = alu_valid_i && alu_ready_o;
    assign lsu_fire = lsu_valid_i && lsu_ready_o;

    // Stage 0: pick this cycle's write
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_addr  = alu_addr_i;
        sel_data  = alu_data_i;
        if (fifo_full) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_addr  = fifo_addr_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end else if (alu_fire) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_addr  = fifo_addr_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end
    end

    // Pointers are PTR_W bits wide, so they wrap modulo the power-of-two
    // depth without explicit compare logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (lsu_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (lsu_fire && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!lsu_fire && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // An x0 write is consumed silently. The address and data registers keep
    // their previous value, just as in a cycle with no write.
    always_comb begin
        wr_en_d   = sel_valid && (sel_addr != 5'd0);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    // Stage 0 -> 1: control and write-port registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO payload. This storage is not reset: only slots covered by count_q
    // are ever read.
    always_ff @(posedge clk_i) begin
        if (lsu_fire) begin
            fifo_addr_q[wr_ptr_q] <= lsu_addr_i;
            fifo_data_q[wr_ptr_q] <= lsu_data_i;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

`ifdef RV_WB_HAZARD_EN
    logic [PTR_W-1:0] scan_ptr;

    // Scan the occupied FIFO slots from the head, and also the write
    // currently on the port, because the register file has not absorbed it.
    always_comb begin
        query_hit_o = 1'b0;
        scan_ptr    = rd_ptr_q;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            scan_ptr = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[scan_ptr] == query_addr_i)) begin
                query_hit_o = 1'b1;
            end
        end
        if (wr_en_q && (wr_addr_q == query_addr_i)) begin
            query_hit_o = 1'b1;
        end
        if (query_addr_i == 5'd0) begin
            query_hit_o = 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rv_wb_unit.sv
// tb_rv_wb_unit -- bench for rv_wb_unit.
// Directed vectors; expected register-file writes are queued when each
// vector is issued, and a monitor pops and compares them whenever the DUT
// raises wr_en_o. Direct checks cover handshake, reset and hold behaviour.
// The hazard-query section is built only when RV_WB_HAZARD_EN is defined.

module tb_rv_wb_unit;

    localparam int LSU_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_addr = '0;
    logic [31:0] lsu_data = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
`ifdef RV_WB_HAZARD_EN
    logic [4:0]  query_addr = '0;
    logic        query_hit;
`endif

    rv_wb_unit #(.LSU_DEPTH(LSU_DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .alu_valid_i (alu_valid),
        .alu_ready_o (alu_ready),
        .alu_addr_i  (alu_addr),
        .alu_data_i  (alu_data),
        .lsu_valid_i (lsu_valid),
        .lsu_ready_o (lsu_ready),
        .lsu_addr_i  (lsu_addr),
        .lsu_data_i  (lsu_data),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data)
`ifdef RV_WB_HAZARD_EN
        ,
        .query_addr_i(query_addr),
        .query_hit_o (query_hit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;

    // Mixed ALU/LSU stream, one row per cycle.
    int t3_av  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int t3_aa  [8] = '{10, 11, 12, 12, 13, 13, 0, 0};
    int t3_lv  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int t3_la  [8] = '{1, 2, 3, 3, 0, 0, 0, 0};
    int t3_rdy [8] = '{1, 1, 0, 1, 0, 1, 1, 1};

    // LSU-only stream keeping one entry buffered (push+pop each cycle).
    int t4_lv  [4] = '{1, 1, 1, 0};
    int t4_la  [4] = '{20, 21, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every asserted write must match the next queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("post_rst_alu_ready", 32'(alu_ready), 32'd1);

        // Single ALU write, latency 1, exactly one cycle
        alu_valid = 1'b1;
        alu_addr  = 5'd5;
        alu_data  = 32'h1234;
        check("t1_alu_ready", 32'(alu_ready), 32'd1);
        expect_wr(5'd5, 32'h1234);
        step();
        alu_valid = 1'b0;
        check("t1_wr_en", 32'(wr_en), 32'd1);
        check("t1_wr_addr", 32'(wr_addr), 32'd5);
        check("t1_wr_data", wr_data, 32'h1234);
        step();
        check("t1_wr_en_drop", 32'(wr_en), 32'd0);
        check("t1_hold_addr", 32'(wr_addr), 32'd5);
        check("t1_hold_data", wr_data, 32'h1234);

        // ALU write to x0: accepted, no register-file write
        alu_valid = 1'b1;
        alu_addr  = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        check("t2_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        check("t2_wr_en", 32'(wr_en), 32'd0);
        check("t2_hold_addr", 32'(wr_addr), 32'd5);
        check("t2_hold_data", wr_data, 32'h1234);
        step();

        // ALU and LSU both streaming: ALU first, FIFO fills, LSU in order
        expect_wr(5'd10, 32'hA000_000A);
        expect_wr(5'd11, 32'hA000_000B);
        expect_wr(5'd1,  32'h5000_0001);
        expect_wr(5'd12, 32'hA000_000C);
        expect_wr(5'd2,  32'h5000_0002);
        expect_wr(5'd13, 32'hA000_000D);
        expect_wr(5'd3,  32'h5000_0003);
        for (int c = 0; c < 8; c++) begin
            alu_valid = (t3_av[c] != 0);
            alu_addr  = 5'(t3_aa[c]);
            alu_data  = 32'hA000_0000 | 32'(t3_aa[c]);
            lsu_valid = (t3_lv[c] != 0);
            lsu_addr  = 5'(t3_la[c]);
            lsu_data  = 32'h5000_0000 | 32'(t3_la[c]);
            check($sformatf("t3_alu_ready_c%0d", c), 32'(alu_ready), 32'(t3_rdy[c]));
            check($sformatf("t3_lsu_ready_c%0d", c), 32'(lsu_ready), 32'(t3_rdy[c]));
            step();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        step();
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // One entry buffered, push and pop together; x0 load consumed silently
        expect_wr(5'd20, 32'h5000_0014);
        expect_wr(5'd21, 32'h5000_0015);
        for (int c = 0; c < 4; c++) begin
            lsu_valid = (t4_lv[c] != 0);
            lsu_addr  = 5'(t4_la[c]);
            lsu_data  = 32'h5000_0000 | 32'(t4_la[c]);
            check($sformatf("t4_lsu_ready_c%0d", c), 32'(lsu_ready), 32'd1);
            step();
        end
        lsu_valid = 1'b0;
        check("t4_x0_wr_en", 32'(wr_en), 32'd0);
        check("t4_hold_addr", 32'(wr_addr), 32'd21);
        check("t4_hold_data", wr_data, 32'h5000_0015);
        step();
        check("t4_lsu_ready_end", 32'(lsu_ready), 32'd1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two buffered loads: they are discarded
        expect_wr(5'd30, 32'hA000_001E);
        expect_wr(5'd31, 32'hA000_001F);
        alu_valid = 1'b1; alu_addr = 5'd30; alu_data = 32'hA000_001E;
        lsu_valid = 1'b1; lsu_addr = 5'd8;  lsu_data = 32'h5000_0008;
        step();
        alu_addr = 5'd31; alu_data = 32'hA000_001F;
        lsu_addr = 5'd9;  lsu_data = 32'h5000_0009;
        step();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("t6_full_lsu_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 32'd0);
        check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_rst_wr_data", wr_data, 32'd0);
        check("t6_rst_alu_ready", 32'(alu_ready), 32'd1);
        check("t6_rst_lsu_ready", 32'(lsu_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t6_no_write_c%0d", c), 32'(wr_en), 32'd0);
        end
        check("t6_ready_after", 32'(alu_ready), 32'd1);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

`ifdef RV_WB_HAZARD_EN
        // Hazard query on a load buffered behind ALU traffic
        query_addr = 5'd7;
        #1;
        check("t7_hit_idle", 32'(query_hit), 32'd0);
        expect_wr(5'd14, 32'hA000_000E);
        expect_wr(5'd15, 32'hA000_000F);
        expect_wr(5'd7,  32'h5000_0007);
        alu_valid = 1'b1; alu_addr = 5'd14; alu_data = 32'hA000_000E;
        lsu_valid = 1'b1; lsu_addr = 5'd7;  lsu_data = 32'h5000_0007;
        step();
        alu_addr = 5'd15; alu_data = 32'hA000_000F;
        lsu_valid = 1'b0;
        #1;
        check("t7_hit_buffered", 32'(query_hit), 32'd1);
        step();
        alu_valid = 1'b0;
        #1;
        check("t7_hit_still", 32'(query_hit), 32'd1);
        query_addr = 5'd0;
        #1;
        check("t7_hit_x0", 32'(query_hit), 32'd0);
        query_addr = 5'd7;
        step();
        check("t7_hit_on_port", 32'(query_hit), 32'd1);
        check("t7_port_addr", 32'(wr_addr), 32'd7);
        step();
        check("t7_hit_cleared", 32'(query_hit), 32'd0);
        check("t7_drained", 32'(exp_q.size()), 32'd0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
